branch_pc_select: RTL and testbench
===================================

BRANCH_PC_SELECT -- requirements
Module: branch_pc_select

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of 2-bit predictor counters (power of two, 4..256).
REQ-002 The block SHALL have parameter IDX_W, default $clog2(DEPTH), meaning the width of the table index.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port Branch, input, 1 bit: the current instruction is a conditional branch.
REQ-007 Port BrType, input, 2 bits: branch condition, 00 EQ, 01 NE, 10 LT, 11 GE.
REQ-008 Port Zero, input, 1 bit: ALU result is zero.
REQ-009 Port Negative, input, 1 bit: ALU result is negative.
REQ-010 Port BrIdx, input, IDX_W bits: table index of the resolving branch (PC word bits).
REQ-011 Port BrPred, input, 1 bit: the prediction previously issued for this branch.
REQ-012 Port LookupIdx, input, IDX_W bits: fetch-stage index to predict.
REQ-013 Port PCSel, output, 1 bit: resolved branch taken.
REQ-014 Port PredTaken, output, 1 bit: prediction for LookupIdx.
REQ-015 Port Mispredict, output, 1 bit: registered flag, prior-cycle branch resolved opposite to BrPred.

Function
REQ-016 Taken SHALL be computed as: EQ=Zero, NE=!Zero, LT=Negative, GE=!Negative.
REQ-017 PCSel SHALL equal Branch AND Taken, combinationally in the same cycle.
REQ-018 PredTaken SHALL be combinational and equal to bit 1 of counter[LookupIdx].
REQ-019 On a clock edge with Branch=1, counter[BrIdx] SHALL increment if Taken and decrement if not, saturating at 11 and 00.
REQ-020 On a clock edge with Branch=0, no counter SHALL change.
REQ-021 If LookupIdx==BrIdx in the same cycle, PredTaken SHALL reflect the pre-update value; there is no bypass.
REQ-022 Mispredict SHALL be registered to Branch AND (Taken != BrPred), giving one-cycle latency and a one-cycle pulse per event.
REQ-023 Back-to-back branches to the same index SHALL each apply one step.

Reset
REQ-024 While rst_n=0, every counter SHALL be 01 (weakly not-taken) and Mispredict SHALL be 0, regardless of clk.
REQ-025 A reset asserted mid-operation SHALL discard any in-flight update.
REQ-026 After deassertion, the first rising edge SHALL be allowed to update normally.

Configuration
REQ-027 Macro BPU_STATS_EN SHALL, when defined, add output MissCount (16 bits), which increments on every Mispredict pulse.
REQ-028 MissCount SHALL saturate at 0xFFFF and SHALL reset to 0.
REQ-029 When BPU_STATS_EN is undefined, the MissCount port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 A shared package branch_pkg SHALL hold the BrType encodings and counter constants: SNT=00, WNT=01, WT=10, ST=11.
REQ-031 A sub-module sat_counter2 SHALL implement one 2-bit saturating counter with an update enable and a direction input.
REQ-032 branch_pc_select SHALL instantiate sat_counter2 DEPTH times.
REQ-033 Condition decode, PCSel, and Mispredict SHALL stay in the top level.

Verification
REQ-034 Reset check: after reset, all LookupIdx 0..15 -> PredTaken=0, Mispredict=0, PCSel=0 with Branch=0.
REQ-035 Condition truth table: for each BrType with Zero/Negative swept -> PCSel matches REQ-016/017 in the same cycle.
REQ-036 Saturation: five taken branches at BrIdx=3 -> counter 01->10->11->11->11, and PredTaken(3)=1 from after the first edge.
REQ-037 Collision: LookupIdx=BrIdx=5 with counter=01 and a taken branch -> PredTaken=0 that cycle and 1 the next.
REQ-038 Mispredict: BrPred=0 with a taken BEQ (Zero=1) -> Mispredict=1 exactly one cycle later, then 0; with BPU_STATS_EN defined, MissCount goes 0->1.
REQ-039 Async reset: pulse rst_n low between edges after training index 7 to 11 -> PredTaken(7)=0 immediately and Mispredict cleared.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution / prediction block:
// branch condition encodings, 2-bit predictor counter states and the
// condition-evaluation helper used by the top level.
package branch_pkg;

    // Branch condition selected by BrType.
    typedef enum logic [1:0] {
        BR_EQ = 2'b00,
        BR_NE = 2'b01,
        BR_LT = 2'b10,
        BR_GE = 2'b11
    } br_type_e;

    // 2-bit predictor counter states; bit 1 is the taken prediction.
    localparam logic [1:0] CNT_SNT = 2'b00;  // strongly not-taken
    localparam logic [1:0] CNT_WNT = 2'b01;  // weakly not-taken (reset value)
    localparam logic [1:0] CNT_WT  = 2'b10;  // weakly taken
    localparam logic [1:0] CNT_ST  = 2'b11;  // strongly taken

    // Resolve a branch condition from the ALU flags.
    function automatic logic br_taken(input logic [1:0] br_type,
                                      input logic       zero,
                                      input logic       negative);
        logic taken;
        case (br_type_e'(br_type))
            BR_EQ:   taken = zero;
            BR_NE:   taken = ~zero;
            BR_LT:   taken = negative;
            BR_GE:   taken = ~negative;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// One 2-bit saturating predictor counter. When en_i is high the counter
// steps up (inc_i=1) or down (inc_i=0), holding at CNT_ST / CNT_SNT.
// Resets asynchronously to CNT_WNT.
module sat_counter2
    import branch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       inc_i,
    output logic [1:0] cnt_o
);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    // Next-state: one saturating step when enabled, otherwise hold.
    always_comb begin
        // NOTE: cnt_d is assigned a default first so every path drives it and no latch is inferred.
        cnt_d = cnt_q;
        if (en_i) begin
            if (inc_i && (cnt_q != CNT_ST)) begin
                cnt_d = cnt_q + 2'd1;
            end else if (!inc_i && (cnt_q != CNT_SNT)) begin
                cnt_d = cnt_q - 2'd1;
            end
        end
    end

    // State register with asynchronous reset to weakly not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rst_n) begin
            cnt_q <= CNT_WNT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_pc_select.sv
// Branch resolution and 2-bit bimodal prediction.
// PCSel resolves the current conditional branch combinationally; a table
// of DEPTH saturating counters supplies PredTaken for the fetch index and
// is trained by resolving branches. Mispredict is a registered one-cycle
// pulse flagging the previous cycle's wrong prediction.
// Optional build macro BPU_STATS_EN adds a saturating 16-bit MissCount.
module branch_pc_select
    import branch_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Branch,
    input  logic [1:0]       BrType,
    input  logic             Zero,
    input  logic             Negative,
    input  logic [IDX_W-1:0] BrIdx,
    input  logic             BrPred,
    input  logic [IDX_W-1:0] LookupIdx,
    output logic             PCSel,
    output logic             PredTaken,
    output logic             Mispredict
`ifdef BPU_STATS_EN
    ,
    output logic [15:0]      MissCount
`endif
);

    logic       taken;
    logic       mispredict_d;
    logic       mispredict_q;
    logic [1:0] cnt [DEPTH];

    // Condition decode, same-cycle PC select and misprediction detect.
    always_comb begin
        taken        = br_taken(BrType, Zero, Negative);
        PCSel        = Branch & taken;
        mispredict_d = Branch & (taken != BrPred);
    end

    // Predictor table: one counter per index, trained only by the branch at BrIdx.
    // NOTE: the table is built from flops rather than a RAM, so every entry can legally take the async reset.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ctr
        sat_counter2 u_ctr (
            .clk   (clk),
            .rst_n (rst_n),
            .en_i  (Branch && (BrIdx == IDX_W'(i))),
            .inc_i (taken),
            .cnt_o (cnt[i])
        );
    end

    // Prediction reads the pre-update counter; there is no bypass from BrIdx.
    assign PredTaken = cnt[LookupIdx][1];

    // Registered misprediction pulse, one cycle after the resolving branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict_q <= 1'b0;
        end else begin
            mispredict_q <= mispredict_d;
        end
    end

    assign Mispredict = mispredict_q;

`ifdef BPU_STATS_EN
    logic [15:0] miss_count_q;
    logic [15:0] miss_count_d;

    // Count each misprediction pulse as it is registered, saturating at all-ones.
    always_comb begin
        miss_count_d = miss_count_q;
        if (mispredict_d && (miss_count_q != 16'hFFFF)) begin
            miss_count_d = miss_count_q + 16'd1;
        end
    end

    // Statistics counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_count_q <= 16'd0;
        end else begin
            miss_count_q <= miss_count_d;
        end
    end

    assign MissCount = miss_count_q;
`endif

endmodule

// File: tb/tb_branch_pc_select.sv
// Self-checking bench for branch_pc_select (default build, DEPTH=16).
// A behavioural model (integer counter array, spec-level condition rules)
// predicts PCSel, PredTaken and Mispredict for directed and random steps.
module tb_branch_pc_select;

    localparam int DEPTH = 16;
    localparam int IDX_W = 4;

    logic             clk;
    logic             rst_n;
    logic             Branch;
    logic [1:0]       BrType;
    logic             Zero;
    logic             Negative;
    logic [IDX_W-1:0] BrIdx;
    logic             BrPred;
    logic [IDX_W-1:0] LookupIdx;
    logic             PCSel;
    logic             PredTaken;
    logic             Mispredict;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int   model_ctr [DEPTH];
    logic model_mis;

    branch_pc_select #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Branch     (Branch),
        .BrType     (BrType),
        .Zero       (Zero),
        .Negative   (Negative),
        .BrIdx      (BrIdx),
        .BrPred     (BrPred),
        .LookupIdx  (LookupIdx),
        .PCSel      (PCSel),
        .PredTaken  (PredTaken),
        .Mispredict (Mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic ref_taken(input logic [1:0] bt, input logic z, input logic n);
        if (bt == 2'd0) return z;
        if (bt == 2'd1) return !z;
        if (bt == 2'd2) return n;
        return !n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_ctr[i] = 1;
        model_mis = 1'b0;
    endtask

    // Check combinational outputs, clock once, update model, check Mispredict.
    task automatic step(input string tag);
        logic t;
        int   k;
        #1;
        t = ref_taken(BrType, Zero, Negative);
        check({tag, ".PCSel"}, PCSel, Branch && t);
        check({tag, ".PredTaken"}, PredTaken, model_ctr[LookupIdx] >= 2);
        k = BrIdx;
        model_mis = Branch && (t != BrPred);
        if (Branch) begin
            if (t) model_ctr[k] = (model_ctr[k] == 3) ? 3 : model_ctr[k] + 1;
            else   model_ctr[k] = (model_ctr[k] == 0) ? 0 : model_ctr[k] - 1;
        end
        @(posedge clk);
        #1;
        check({tag, ".Mispredict"}, Mispredict, model_mis);
    endtask

    task automatic drive(input logic br, input logic [1:0] bt, input logic z, input logic n,
                         input int bidx, input logic pred, input int lidx);
        Branch    = br;
        BrType    = bt;
        Zero      = z;
        Negative  = n;
        BrIdx     = IDX_W'(bidx);
        BrPred    = pred;
        LookupIdx = IDX_W'(lidx);
    endtask

    initial begin
        drive(1'b0, 2'd0, 1'b0, 1'b0, 0, 1'b0, 0);
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state: every entry predicts not-taken, no mispredict, no PCSel.
        for (int i = 0; i < DEPTH; i++) begin
            LookupIdx = IDX_W'(i);
            #1;
            check("reset.PredTaken", PredTaken, 1'b0);
        end
        check("reset.Mispredict", Mispredict, 1'b0);
        check("reset.PCSel", PCSel, 1'b0);

        // Collision at index 5: pre-update value visible, updated value next cycle.
        drive(1'b1, 2'd0, 1'b1, 1'b0, 5, 1'b1, 5);
        #1;
        check("collide.pre", PredTaken, 1'b0);
        step("collide");
        drive(1'b0, 2'd0, 1'b0, 1'b0, 5, 1'b0, 5);
        #1;
        check("collide.post", PredTaken, 1'b1);

        // Saturation at index 3: five taken branches, then walk back down.
        for (int s = 0; s < 5; s++) begin
            drive(1'b1, 2'd1, 1'b0, 1'b0, 3, 1'b1, 3);
            step("sat.up");
            #1;
            check("sat.up.pred", PredTaken, 1'b1);
        end
        drive(1'b1, 2'd0, 1'b0, 1'b0, 3, 1'b1, 3);
        step("sat.down1");
        #1;
        check("sat.down1.pred", PredTaken, 1'b1);   // 11 -> 10 proves it held at 11
        drive(1'b1, 2'd0, 1'b0, 1'b0, 3, 1'b1, 3);
        step("sat.down2");
        #1;
        check("sat.down2.pred", PredTaken, 1'b0);   // 10 -> 01
        for (int s = 0; s < 3; s++) begin
            drive(1'b1, 2'd2, 1'b0, 1'b0, 3, 1'b0, 3);
            step("sat.floor");
        end

        // Condition truth table, with Branch=0 and Branch=1.
        for (int bt = 0; bt < 4; bt++) begin
            for (int zn = 0; zn < 4; zn++) begin
                for (int br = 0; br < 2; br++) begin
                    drive(br[0], bt[1:0], zn[0], zn[1], 9, 1'b0, 9);
                    step("truth");
                end
            end
        end

        // Mispredict pulse: predicted not-taken, BEQ taken.
        drive(1'b1, 2'd0, 1'b1, 1'b0, 2, 1'b0, 2);
        step("mis.event");
        check("mis.pulse", Mispredict, 1'b1);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 2, 1'b0, 2);
        step("mis.idle");
        check("mis.clear", Mispredict, 1'b0);

        // Train index 7 to 11 with the last step mispredicted, then async reset mid-cycle.
        model_reset();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 2'd3, 1'b0, 1'b0, 7, 1'b1, 7);
        step("train7.a");
        drive(1'b1, 2'd3, 1'b0, 1'b0, 7, 1'b0, 7);
        step("train7.b");
        check("train7.mis", Mispredict, 1'b1);
        check("train7.pred", PredTaken, 1'b1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("areset.pred7", PredTaken, 1'b0);
        check("areset.mis", Mispredict, 1'b0);

        // In-flight update discarded: taken branch held across an edge during reset.
        drive(1'b1, 2'd0, 1'b1, 1'b0, 7, 1'b0, 7);
        @(posedge clk);
        #1;
        check("areset.hold.mis", Mispredict, 1'b0);
        check("areset.hold.pred", PredTaken, 1'b0);
        rst_n = 1'b1;
        // First edge after release updates normally: 01 -> 10.
        step("release.first");
        #1;
        check("release.pred7", PredTaken, 1'b1);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, 1),
                  ($urandom_range(0, 3) == 0) ? int'(BrIdx) : $urandom_range(0, DEPTH - 1));
            step("rand");
        end

        // Final sweep of every entry against the model.
        Branch = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            LookupIdx = IDX_W'(i);
            #1;
            check("final.PredTaken", PredTaken, model_ctr[i] >= 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
